mem_to_fifo: RTL and testbench
==============================

# mem_to_fifo

Read-side engine of the pcap replay memory path. It drains the four per-queue circular buffers held in QDR SRAM, which are filled by the write engine. Each queue's committed tail is compared with this block's head, and burst reads are issued round-robin. Returned beats are pushed, tagged with their queue ID, into the downstream replay output FIFO, and each queue's head pointer is returned to the writer for its full check.

## Interface
- NUM_QUEUES, 4: queue count (fixed at 4; the address map uses 2 queue-select bits).
- NUM_QUEUES_BITS, log2(NUM_QUEUES): QID width.
- MEM_ADDR_WIDTH, 19: SRAM burst-address width; bits [MEM_ADDR_WIDTH-1:MEM_ADDR_WIDTH-2] select the queue.
- MEM_DATA_WIDTH, 72: width of each read-data half.
- FIFO_DATA_WIDTH, 2*MEM_DATA_WIDTH: output word width.
- TAG_DEPTH, 16: maximum reads outstanding; power of 2.
- clk  in  1  sole clock.
- rst  in  1  reset; asynchronous, active-high.
- mem_ad_r_n  out  1  read-address strobe, active low, registered.
- mem_rd_full  in  1  memory controller read-command queue full.
- mem_ad_rd  out  MEM_ADDR_WIDTH  read burst address, registered.
- mem_rd_vld  in  1  read-data beat valid; beats return in issue order, 2 beats per address.
- mem_qrl, mem_qrh  in  MEM_DATA_WIDTH each  low and high halves of a read beat.
- fifo_wr_en  out  1  output FIFO write, registered.
- fifo_data  out  FIFO_DATA_WIDTH  {mem_qrh, mem_qrl}, registered.
- fifo_qid  out  NUM_QUEUES_BITS  queue of fifo_data.
- fifo_prog_full  in  NUM_QUEUES  per-queue flag; asserted when fewer than 2*TAG_DEPTH words are free.
- qN_addr_tail  in  MEM_ADDR_WIDTH-2  (N=0..3) committed write tail in burst addresses.
- qN_addr_head  out  MEM_ADDR_WIDTH-2  (N=0..3) committed read head.
- cal_done  in  1  memory calibration complete; no reads are issued while low.
- protocol_err  out  1  sticky; set when a beat arrives with no outstanding tag.

## Operation
- Per-queue state:
  - issue pointer rd_ptrN (MEM_ADDR_WIDTH-2 bits).
  - committed head headN, which drives qN_addr_head.
  - All wrap modulo 2^(MEM_ADDR_WIDTH-2) with natural overflow.
- Queue N is eligible when all hold: rd_ptrN != qN_addr_tail, !fifo_prog_full[N], tag count < TAG_DEPTH, !mem_rd_full, and cal_done.
- Arbiter (states IDLE/ISSUE are implicit: at most one issue per cycle):
  - Round-robin search starts at last_grant+1 mod 4.
  - On a grant: mem_ad_rd <= {N[1:0], rd_ptrN}, mem_ad_r_n <= 0, rd_ptrN += 1, N is pushed to the tag FIFO, last_grant <= N.
  - With no grant, mem_ad_r_n <= 1 and mem_ad_rd holds its value.
- Tag FIFO:
  - TAG_DEPTH entries of QID, with occupancy counter 0..TAG_DEPTH.
  - A push and a pop in the same cycle leave the count unchanged.
- Return path:
  - Beat toggle b starts at 0.
  - On mem_rd_vld with the tag FIFO non-empty: fifo_wr_en <= 1, fifo_data <= {mem_qrh, mem_qrl}, fifo_qid <= tag head, b toggles.
  - On the second beat (b==1): the tag is popped and head[tag] += 1.
  - headN therefore advances only after both words of an address are written, so the writer can never overwrite unread data.
- Spurious beat (mem_rd_vld while the tag FIFO is empty): the beat is dropped, fifo_wr_en stays 0, protocol_err <= 1.
- fifo_prog_full is sampled only at issue. Beats already in flight are always written, so the 2*TAG_DEPTH threshold guarantees no overflow.

## Timing
- Reset (asynchronous) values:
  - mem_ad_r_n=1, mem_ad_rd=0, fifo_wr_en=0, fifo_data=0, fifo_qid=0, protocol_err=0.
  - All rd_ptrN and headN = 0, tag count = 0, b=0, last_grant=3, so queue 0 is checked first.
- Issue latency: eligibility at cycle t gives the strobe and address at t+1.
- Return latency: mem_rd_vld at t gives fifo_wr_en at t+1.
- Head update: headN changes at the clock edge after the second beat, the same edge as that beat's fifo_wr_en.
- Throughput: one address per cycle across all queues when unthrottled. A single queue sustains one address per cycle while eligible.
- Boundary cases:
  - A tail update at cycle t is seen at t, with no internal register.
  - When rd_ptrN == tail, the queue is idle even if the tail wrapped a full lap; the writer's full margin prevents that case.
  - Reset mid-operation: all tags are discarded. Beats returned after reset count as spurious, so the bench must reset the memory model alongside this block.

## Test plan
- Single queue:
  - Stimulus: q1_addr_tail=3, all others 0.
  - Required: three reads to addresses 0x20000, 0x20001, 0x20002 on consecutive cycles.
  - Required: 6 FIFO words with fifo_qid=1.
  - Required: q1_addr_head steps 1, 2, 3, each after beats 2, 4, 6.
- Round robin:
  - Stimulus: all tails = 2.
  - Required issue order: q0, q1, q2, q3, q0, q1, q2, q3.
  - Required: 16 words out, then all heads = 2.
- Backpressure:
  - Stimulus: memory latency held off, fifo_prog_full=0, tail0=40.
  - Required: exactly 16 issues, then the strobe stays high until beats return.
  - Stimulus: fifo_prog_full[0]=1.
  - Required: no further q0 issues, and in-flight beats are still written.
- Wrap:
  - Stimulus: preload q2 rd_ptr/head to 0x1FFFF, tail=0x00001.
  - Required: reads to 0x5FFFF then 0x40000, and q2_addr_head=0x00001.
- Gating:
  - Stimulus: cal_done=0 or mem_rd_full=1 with a non-empty queue.
  - Required: zero issues. Issuing resumes the cycle after release.
- Error and reset:
  - Stimulus: mem_rd_vld with nothing outstanding.
  - Required: protocol_err=1 and no fifo_wr_en.
  - Stimulus: assert rst mid-burst.
  - Required: all outputs take their reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mem_to_fifo_if.sv
// mem_to_fifo_if: SRAM read port plus replay output FIFO write port.
// The read engine is the master; the memory controller and FIFO are the slave.
interface mem_to_fifo_if #(
  parameter int NUM_QUEUES      = 4,
  parameter int NUM_QUEUES_BITS = $clog2(NUM_QUEUES),
  parameter int MEM_ADDR_WIDTH  = 19,
  parameter int MEM_DATA_WIDTH  = 72
);
  localparam int FIFO_DATA_WIDTH = 2 * MEM_DATA_WIDTH;

  logic                       mem_ad_r_n;
  logic                       mem_rd_full;
  logic [MEM_ADDR_WIDTH-1:0]  mem_ad_rd;
  logic                       mem_rd_vld;
  logic [MEM_DATA_WIDTH-1:0]  mem_qrl;
  logic [MEM_DATA_WIDTH-1:0]  mem_qrh;
  logic                       fifo_wr_en;
  logic [FIFO_DATA_WIDTH-1:0] fifo_data;
  logic [NUM_QUEUES_BITS-1:0] fifo_qid;
  logic [NUM_QUEUES-1:0]      fifo_prog_full;

  modport master (
    output mem_ad_r_n, mem_ad_rd, fifo_wr_en, fifo_data, fifo_qid,
    input  mem_rd_full, mem_rd_vld, mem_qrl, mem_qrh, fifo_prog_full
  );

  modport slave (
    input  mem_ad_r_n, mem_ad_rd, fifo_wr_en, fifo_data, fifo_qid,
    output mem_rd_full, mem_rd_vld, mem_qrl, mem_qrh, fifo_prog_full
  );
endinterface

// File: rtl/mem_to_fifo.sv
// mem_to_fifo: read-side engine of the pcap replay memory path. Issues
// round-robin burst reads from four circular queues held in QDR SRAM and
// pushes the returned beats, tagged with their queue, into the replay FIFO.
// A queue's head only advances once both words of an address are written.
module mem_to_fifo #(
  parameter int NUM_QUEUES      = 4,
  parameter int NUM_QUEUES_BITS = $clog2(NUM_QUEUES),
  parameter int MEM_ADDR_WIDTH  = 19,
  parameter int MEM_DATA_WIDTH  = 72,
  parameter int FIFO_DATA_WIDTH = 2 * MEM_DATA_WIDTH,
  parameter int TAG_DEPTH       = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  mem_to_fifo_if.master             bus,
  input  logic [MEM_ADDR_WIDTH-3:0] i_q0_addr_tail,
  input  logic [MEM_ADDR_WIDTH-3:0] i_q1_addr_tail,
  input  logic [MEM_ADDR_WIDTH-3:0] i_q2_addr_tail,
  input  logic [MEM_ADDR_WIDTH-3:0] i_q3_addr_tail,
  output logic [MEM_ADDR_WIDTH-3:0] o_q0_addr_head,
  output logic [MEM_ADDR_WIDTH-3:0] o_q1_addr_head,
  output logic [MEM_ADDR_WIDTH-3:0] o_q2_addr_head,
  output logic [MEM_ADDR_WIDTH-3:0] o_q3_addr_head,
  input  logic                      i_cal_done,
  output logic                      o_protocol_err
);

  localparam int PTR_W  = MEM_ADDR_WIDTH - 2;
  localparam int TAG_AW = $clog2(TAG_DEPTH);
  localparam int CNT_W  = TAG_AW + 1;
  localparam logic [CNT_W-1:0] TAG_FULL = CNT_W'(TAG_DEPTH);

  // Per-queue pointers
  logic [PTR_W-1:0]           w_tail  [NUM_QUEUES];
  logic [PTR_W-1:0]           r_rdPtr [NUM_QUEUES];
  logic [PTR_W-1:0]           r_head  [NUM_QUEUES];

  // Arbitration
  logic [NUM_QUEUES-1:0]      w_elig;
  logic                       w_tagRoom;
  logic [NUM_QUEUES_BITS-1:0] r_lastGrant;
  logic [NUM_QUEUES_BITS-1:0] w_candIdx;
  logic [NUM_QUEUES_BITS-1:0] w_grantIdx;
  logic                       w_grantVld;
  logic                       r_adRn;
  logic [MEM_ADDR_WIDTH-1:0]  r_adRd;

  // Tag FIFO of queue IDs for reads in flight
  logic [NUM_QUEUES_BITS-1:0] r_tagMem [TAG_DEPTH];
  logic [TAG_AW-1:0]          r_tagWrPtr;
  logic [TAG_AW-1:0]          r_tagRdPtr;
  logic [CNT_W-1:0]           r_tagCount;
  logic                       w_tagEmpty;
  logic [NUM_QUEUES_BITS-1:0] w_tagHead;
  logic                       w_push;
  logic                       w_pop;

  // Return path
  logic [MEM_DATA_WIDTH-1:0]  w_qrl;
  logic [MEM_DATA_WIDTH-1:0]  w_qrh;
  logic                       w_beatOk;
  logic                       w_spurious;
  logic                       r_beat;
  logic                       r_wrEn;
  logic [FIFO_DATA_WIDTH-1:0] r_fifoData;
  logic [NUM_QUEUES_BITS-1:0] r_fifoQid;
  logic                       r_protoErr;

  assign w_tail[0] = i_q0_addr_tail;
  assign w_tail[1] = i_q1_addr_tail;
  assign w_tail[2] = i_q2_addr_tail;
  assign w_tail[3] = i_q3_addr_tail;

  assign w_qrl      = bus.mem_qrl;
  assign w_qrh      = bus.mem_qrh;
  assign w_tagEmpty = (r_tagCount == '0);
  assign w_tagHead  = r_tagMem[r_tagRdPtr];
  assign w_beatOk   = bus.mem_rd_vld && !w_tagEmpty;
  assign w_spurious = bus.mem_rd_vld && w_tagEmpty;
  assign w_pop      = w_beatOk && r_beat;
  assign w_push     = w_grantVld;

  // A queue may issue when it has unread data, downstream room, a free tag and a ready memory
  always_comb begin
    w_tagRoom = (r_tagCount < TAG_FULL);
    for (int n = 0; n < NUM_QUEUES; n++) begin
      w_elig[n] = (r_rdPtr[n] != w_tail[n]) && !bus.fifo_prog_full[n] &&
                  w_tagRoom && !bus.mem_rd_full && i_cal_done;
    end
  end

  // Round-robin pick starting one past the last queue granted
  always_comb begin
    w_grantVld = 1'b0;
    w_grantIdx = '0;
    w_candIdx  = '0;
    for (int k = 1; k <= NUM_QUEUES; k++) begin
      w_candIdx = NUM_QUEUES_BITS'(32'(r_lastGrant) + k);
      if (!w_grantVld && w_elig[w_candIdx]) begin
        w_grantVld = 1'b1;
        w_grantIdx = w_candIdx;
      end
    end
  end

  // Issue side: registered strobe/address, per-queue issue pointers, grant memory
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_adRn      <= 1'b1;
      r_adRd      <= '0;
      r_lastGrant <= NUM_QUEUES_BITS'(NUM_QUEUES - 1);
      for (int n = 0; n < NUM_QUEUES; n++) begin
        r_rdPtr[n] <= '0;
      end
    end else if (w_grantVld) begin
      r_adRn               <= 1'b0;
      r_adRd               <= MEM_ADDR_WIDTH'({w_grantIdx, r_rdPtr[w_grantIdx]});
      r_rdPtr[w_grantIdx]  <= r_rdPtr[w_grantIdx] + PTR_W'(1);
      r_lastGrant          <= w_grantIdx;
    end else begin
      r_adRn <= 1'b1;
    end
  end

  // Tag FIFO pointers and occupancy; a simultaneous push and pop cancel out
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tagWrPtr <= '0;
      r_tagRdPtr <= '0;
      r_tagCount <= '0;
    end else begin
      if (w_push) begin
        r_tagWrPtr <= r_tagWrPtr + TAG_AW'(1);
      end
      if (w_pop) begin
        r_tagRdPtr <= r_tagRdPtr + TAG_AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_tagCount <= r_tagCount + CNT_W'(1);
        2'b01:   r_tagCount <= r_tagCount - CNT_W'(1);
        default: r_tagCount <= r_tagCount;
      endcase
    end
  end

  // Tag storage needs no reset; the occupancy counter says which entries are live
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_tagMem[r_tagWrPtr] <= w_grantIdx;
    end
  end

  // Return side: forward beats, retire a tag and advance its head after the second beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrEn     <= 1'b0;
      r_fifoData <= '0;
      r_fifoQid  <= '0;
      r_beat     <= 1'b0;
      r_protoErr <= 1'b0;
      for (int n = 0; n < NUM_QUEUES; n++) begin
        r_head[n] <= '0;
      end
    end else begin
      r_wrEn <= w_beatOk;
      if (w_beatOk) begin
        r_fifoData <= FIFO_DATA_WIDTH'({w_qrh, w_qrl});
        r_fifoQid  <= w_tagHead;
        r_beat     <= !r_beat;
      end
      if (w_pop) begin
        r_head[w_tagHead] <= r_head[w_tagHead] + PTR_W'(1);
      end
      if (w_spurious) begin
        r_protoErr <= 1'b1;
      end
    end
  end

  assign bus.mem_ad_r_n = r_adRn;
  assign bus.mem_ad_rd  = r_adRd;
  assign bus.fifo_wr_en = r_wrEn;
  assign bus.fifo_data  = r_fifoData;
  assign bus.fifo_qid   = r_fifoQid;
  assign o_q0_addr_head = r_head[0];
  assign o_q1_addr_head = r_head[1];
  assign o_q2_addr_head = r_head[2];
  assign o_q3_addr_head = r_head[3];
  assign o_protocol_err = r_protoErr;

endmodule

// File: tb/tb_mem_to_fifo.sv
// tb_mem_to_fifo: randomized-latency memory model and queue-level scoreboard
// for the replay read engine.
module tb_mem_to_fifo;

  // Narrow address width keeps a full pointer lap to 256 addresses
  localparam int AW = 10;
  localparam int PW = AW - 2;
  localparam int DW = 72;
  localparam int FW = 2 * DW;
  localparam int TD = 16;

  typedef struct {
    logic [AW-1:0] addr;
    int            cyc;
  } rdReq_t;

  typedef struct {
    logic [FW-1:0] data;
    logic [1:0]    qid;
    bit            last;
  } word_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [PW-1:0] tail [4];
  logic [PW-1:0] head [4];
  logic          calDone;
  logic          protoErr;

  mem_to_fifo_if #(.NUM_QUEUES(4), .MEM_ADDR_WIDTH(AW), .MEM_DATA_WIDTH(DW)) bus ();

  mem_to_fifo #(
    .NUM_QUEUES(4), .MEM_ADDR_WIDTH(AW), .MEM_DATA_WIDTH(DW), .TAG_DEPTH(TD)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .i_q0_addr_tail(tail[0]), .i_q1_addr_tail(tail[1]),
    .i_q2_addr_tail(tail[2]), .i_q3_addr_tail(tail[3]),
    .o_q0_addr_head(head[0]), .o_q1_addr_head(head[1]),
    .o_q2_addr_head(head[2]), .o_q3_addr_head(head[3]),
    .i_cal_done(calDone), .o_protocol_err(protoErr)
  );

  always #5 clk = ~clk;

  int            checkCount = 0;
  int            failCount  = 0;
  int            cycleNo    = 0;
  int            issueCount = 0;
  int            wordCount  = 0;
  rdReq_t        rdQ [$];
  word_t         expQ [$];
  logic [AW-1:0] issueLog [$];
  int            issueCyc [$];
  logic [PW-1:0] mPtr  [4];
  logic [PW-1:0] mHead [4];
  logic [AW-1:0] lastAddr;
  bit            memBeat;
  bit            holdOff;
  bit            injectSpurious;
  logic [1:0]    monQ;
  logic [AW-1:0] monA;
  word_t         monW;
  logic [FW-1:0] memWordV;

  task automatic checkOutput(input string tag, input logic [FW-1:0] observed,
                             input logic [FW-1:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Contents of each SRAM burst address; the high half is the complement of the low half
  function automatic logic [FW-1:0] memWord(input logic [AW-1:0] a, input bit beat);
    logic [DW-1:0] lo;
    lo = {8'hA0, 7'h00, beat, 46'h0, a};
    return {~lo, lo};
  endfunction

  function automatic bit isIdle();
    bit idle;
    idle = (expQ.size() == 0) && (rdQ.size() == 0) && bus.mem_ad_r_n;
    for (int q = 0; q < 4; q++) begin
      if (mPtr[q] != tail[q] && !bus.fifo_prog_full[q]) idle = 1'b0;
    end
    return idle;
  endfunction

  // Monitor, scoreboard and SRAM model, all evaluated on the falling edge
  always @(negedge clk) begin
    if (rst) begin
      bus.mem_rd_vld = 1'b0;
      bus.mem_qrl    = '0;
      bus.mem_qrh    = '0;
    end else begin
      cycleNo++;
      if (bus.fifo_wr_en) begin
        wordCount++;
        if (expQ.size() == 0) begin
          checkOutput("unexpected fifo write", 1, 0);
        end else begin
          monW = expQ.pop_front();
          checkOutput("fifo data", bus.fifo_data, monW.data);
          checkOutput("fifo qid", bus.fifo_qid, monW.qid);
          if (monW.last) mHead[monW.qid] = mHead[monW.qid] + 1'b1;
        end
      end
      for (int q = 0; q < 4; q++) begin
        checkOutput($sformatf("head q%0d", q), head[q], mHead[q]);
      end
      if (!bus.mem_ad_r_n) begin
        monQ = bus.mem_ad_rd[AW-1:AW-2];
        checkOutput("issue allowed", (mPtr[monQ] != tail[monQ]) &&
                    !bus.fifo_prog_full[monQ] && calDone && !bus.mem_rd_full, 1);
        checkOutput("issue ptr", bus.mem_ad_rd[PW-1:0], mPtr[monQ]);
        monA = {monQ, mPtr[monQ]};
        expQ.push_back('{memWord(monA, 1'b0), monQ, 1'b0});
        expQ.push_back('{memWord(monA, 1'b1), monQ, 1'b1});
        mPtr[monQ] = mPtr[monQ] + 1'b1;
        issueCount++;
        issueLog.push_back(bus.mem_ad_rd);
        issueCyc.push_back(cycleNo);
        rdQ.push_back('{bus.mem_ad_rd, cycleNo});
        lastAddr = bus.mem_ad_rd;
      end else begin
        checkOutput("addr hold", bus.mem_ad_rd, lastAddr);
      end
      bus.mem_rd_vld = 1'b0;
      if (injectSpurious) begin
        bus.mem_rd_vld = 1'b1;
        bus.mem_qrl    = '1;
        bus.mem_qrh    = '1;
        injectSpurious = 1'b0;
      end else if (!holdOff && rdQ.size() != 0) begin
        if ((cycleNo - rdQ[0].cyc) >= 2 && $urandom_range(0, 3) != 0) begin
          memWordV       = memWord(rdQ[0].addr, memBeat);
          bus.mem_rd_vld = 1'b1;
          bus.mem_qrl    = memWordV[DW-1:0];
          bus.mem_qrh    = memWordV[FW-1:DW];
          if (memBeat) void'(rdQ.pop_front());
          memBeat = !memBeat;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic clearModels();
    rdQ.delete();
    expQ.delete();
    issueLog.delete();
    issueCyc.delete();
    for (int q = 0; q < 4; q++) begin
      mPtr[q]  = '0;
      mHead[q] = '0;
      tail[q]  = '0;
    end
    lastAddr       = '0;
    memBeat        = 1'b0;
    holdOff        = 1'b0;
    injectSpurious = 1'b0;
  endtask

  task automatic applyReset();
    rst = 1'b1;
    clearModels();
    calDone            = 1'b1;
    bus.mem_rd_full    = 1'b0;
    bus.fifo_prog_full = '0;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic applyStimulus(input logic [PW-1:0] t0, input logic [PW-1:0] t1,
                               input logic [PW-1:0] t2, input logic [PW-1:0] t3);
    tail[0] = t0;
    tail[1] = t1;
    tail[2] = t2;
    tail[3] = t3;
  endtask

  task automatic waitDrain(input int budget, input string tag);
    int n;
    n = 0;
    while (!isIdle() && n < budget) begin
      tick(1);
      n++;
    end
    checkOutput(tag, isIdle(), 1);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " strobe"}, bus.mem_ad_r_n, 1);
    checkOutput({tag, " addr"}, bus.mem_ad_rd, 0);
    checkOutput({tag, " wr_en"}, bus.fifo_wr_en, 0);
    checkOutput({tag, " data"}, bus.fifo_data, 0);
    checkOutput({tag, " qid"}, bus.fifo_qid, 0);
    checkOutput({tag, " protocol_err"}, protoErr, 0);
    for (int q = 0; q < 4; q++) checkOutput({tag, " head"}, head[q], 0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int startIssue;
    int startWord;
    logic [AW-1:0] expAddr;

    clearModels();
    calDone            = 1'b1;
    bus.mem_rd_full    = 1'b0;
    bus.fifo_prog_full = '0;
    applyReset();
    checkResetOutputs("reset");

    $display("[TB] single queue");
    startWord = wordCount;
    applyStimulus(0, 3, 0, 0);
    waitDrain(200, "single drain");
    checkOutput("single issues", issueLog.size(), 3);
    for (int i = 0; i < 3; i++) begin
      expAddr = {2'd1, 8'(i)};
      checkOutput("single addr", (i < issueLog.size()) ? issueLog[i] : '1, expAddr);
      checkOutput("single spacing", (i < issueCyc.size()) ? issueCyc[i] - issueCyc[0] : -1, i);
    end
    checkOutput("single words", wordCount - startWord, 6);
    checkOutput("single head", head[1], 3);

    $display("[TB] round robin");
    applyReset();
    startWord = wordCount;
    applyStimulus(2, 2, 2, 2);
    waitDrain(300, "rr drain");
    checkOutput("rr issues", issueLog.size(), 8);
    for (int r = 0; r < 2; r++) begin
      for (int q = 0; q < 4; q++) begin
        expAddr = {2'(q), 8'(r)};
        checkOutput("rr order", (r*4+q < issueLog.size()) ? issueLog[r*4+q] : '1, expAddr);
      end
    end
    checkOutput("rr words", wordCount - startWord, 16);
    for (int q = 0; q < 4; q++) checkOutput("rr head", head[q], 2);

    $display("[TB] backpressure");
    applyReset();
    holdOff    = 1'b1;
    startIssue = issueCount;
    startWord  = wordCount;
    applyStimulus(40, 0, 0, 0);
    tick(30);
    checkOutput("tag limit issues", issueCount - startIssue, TD);
    checkOutput("tag limit strobe", bus.mem_ad_r_n, 1);
    bus.fifo_prog_full = 4'b0001;
    holdOff            = 1'b0;
    waitDrain(400, "prog_full drain");
    checkOutput("prog_full issues", issueCount - startIssue, TD);
    checkOutput("prog_full words", wordCount - startWord, 2*TD);
    checkOutput("prog_full head", head[0], TD);
    bus.fifo_prog_full = '0;
    waitDrain(400, "backpressure drain");
    checkOutput("backpressure head", head[0], 40);

    $display("[TB] wrap");
    applyReset();
    applyStimulus(0, 0, 8'hFF, 0);
    waitDrain(3000, "wrap fill drain");
    checkOutput("wrap pre head", head[2], 8'hFF);
    issueLog.delete();
    applyStimulus(0, 0, 8'h01, 0);
    waitDrain(200, "wrap drain");
    checkOutput("wrap issues", issueLog.size(), 2);
    checkOutput("wrap addr0", (issueLog.size() > 0) ? issueLog[0] : '0, 10'h2FF);
    checkOutput("wrap addr1", (issueLog.size() > 1) ? issueLog[1] : '1, 10'h200);
    checkOutput("wrap head", head[2], 1);

    $display("[TB] gating");
    calDone    = 1'b0;
    startIssue = issueCount;
    applyStimulus(0, 0, 1, 5);
    tick(20);
    checkOutput("cal_done gate", issueCount - startIssue, 0);
    calDone = 1'b1;
    tick(1);
    checkOutput("cal_done resume strobe", bus.mem_ad_r_n, 0);
    checkOutput("cal_done resume addr", bus.mem_ad_rd, 10'h300);
    waitDrain(200, "cal_done drain");
    bus.mem_rd_full = 1'b1;
    startIssue      = issueCount;
    applyStimulus(0, 0, 1, 10);
    tick(20);
    checkOutput("rd_full gate", issueCount - startIssue, 0);
    bus.mem_rd_full = 1'b0;
    tick(1);
    checkOutput("rd_full resume strobe", bus.mem_ad_r_n, 0);
    checkOutput("rd_full resume addr", bus.mem_ad_rd, 10'h305);
    waitDrain(200, "rd_full drain");
    checkOutput("gating head", head[3], 10);

    $display("[TB] spurious beat");
    checkOutput("protocol_err clear", protoErr, 0);
    startWord      = wordCount;
    injectSpurious = 1'b1;
    tick(4);
    checkOutput("protocol_err set", protoErr, 1);
    checkOutput("spurious words", wordCount - startWord, 0);

    $display("[TB] reset mid-burst");
    applyStimulus(30, 30, 30, 30);
    tick(8);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checkResetOutputs("async reset");
    clearModels();
    tick(2);
    rst = 1'b0;
    tick(1);
    applyStimulus(0, 4, 0, 0);
    waitDrain(200, "post reset drain");
    checkOutput("post reset head", head[1], 4);
    checkOutput("post reset protocol_err", protoErr, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
